// File: rtl/tone_sequencer_if.sv
// Control and status bundle between the sound-generator top level and the
// tone sequencer: table write port, playback commands and DAC duty output.
interface tone_sequencer_if #(
   parameter int N  = 8,
   parameter int AW = 4
);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          start;
   logic          stop;
   logic          loop;
   logic [N-1:0]  volume;
   logic [N-1:0]  t_on;
   logic          busy;
   logic          done;
   logic [AW-1:0] note_idx;

   modport master (
      output wr_en, wr_addr, wr_data, start, stop, loop, volume,
      input  t_on, busy, done, note_idx
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, stop, loop, volume,
      output t_on, busy, done, note_idx
   );
endinterface

// File: rtl/tone_sequencer.sv
// Note-table sequencer: plays {half-period, duration} entries in order as a
// square wave on the DAC duty input, alternating between a latched volume and 0.
module tone_sequencer #(
   parameter int N        = 8,
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int TICK_DIV = 1000
) (
   input  logic            clk,
   input  logic            reset,
   tone_sequencer_if.slave bus
);

   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_END} state_t;

   state_t        state;
   logic [15:0]   mem [DEPTH];
   logic [15:0]   entry;
   logic [11:0]   hp_q;
   logic [11:0]   tone_cnt;
   logic [3:0]    dur_rem;
   logic [TW-1:0] tick_cnt;
   logic          phase;
   logic [N-1:0]  vol_q;
   logic [AW-1:0] idx;
   logic          start_ok;

   assign start_ok = (state == S_IDLE) && bus.start && !bus.stop;
   assign entry    = mem[idx];

   // Table has no reset so programmed notes survive a reset; writes are blocked
   // once playback is being launched so the table is frozen while playing.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && bus.wr_en && !start_ok)
         mem[bus.wr_addr] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         hp_q     <= '0;
         tone_cnt <= '0;
         dur_rem  <= '0;
         tick_cnt <= '0;
         phase    <= 1'b0;
         vol_q    <= '0;
         idx      <= '0;
      end else if (bus.stop && state != S_IDLE) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  vol_q <= bus.volume;
                  idx   <= '0;
                  state <= S_FETCH;
               end
            end
            S_FETCH: begin
               hp_q    <= entry[15:4];
               dur_rem <= entry[3:0];
               if (entry[3:0] == 4'd0) begin
                  state <= S_END;
               end else begin
                  state    <= S_PLAY;
                  phase    <= 1'b1;
                  tone_cnt <= '0;
                  tick_cnt <= '0;
               end
            end
            S_PLAY: begin
               // A rest (hp = 0) leaves the tone counter idle.
               if (hp_q != 12'd0) begin
                  if (tone_cnt == hp_q - 12'd1) begin
                     tone_cnt <= '0;
                     phase    <= ~phase;
                  end else begin
                     tone_cnt <= tone_cnt + 12'd1;
                  end
               end
               if (tick_cnt == TW'(TICK_DIV - 1)) begin
                  tick_cnt <= '0;
                  dur_rem  <= dur_rem - 4'd1;
                  if (dur_rem == 4'd1) begin
                     if (idx == AW'(DEPTH - 1)) begin
                        state <= S_END;
                     end else begin
                        idx   <= idx + AW'(1);
                        state <= S_FETCH;
                     end
                  end
               end else begin
                  tick_cnt <= tick_cnt + TW'(1);
               end
            end
            S_END: begin
               if (bus.loop) begin
                  idx   <= '0;
                  state <= S_FETCH;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.t_on     = (state == S_PLAY && phase && hp_q != 12'd0) ? vol_q : '0;
   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = (state == S_END) && !bus.loop && !bus.stop;
   assign bus.note_idx = idx;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICK_DIV = 4 so note timing stays short.
module tb_tone_sequencer;
   localparam int N     = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int TD    = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   tone_sequencer_if #(.N(N), .AW(AW)) bus ();

   tone_sequencer #(.N(N), .DEPTH(DEPTH), .AW(AW), .TICK_DIV(TD)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // After cyc(), outputs reflect the state entered at the edge just passed.
   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr_entry(input logic [AW-1:0] a, input logic [15:0] d);
      bus.wr_addr = a;
      bus.wr_data = d;
      bus.wr_en   = 1'b1;
      cyc();
      bus.wr_en   = 1'b0;
   endtask

   task automatic go(input logic [N-1:0] v);
      bus.volume = v;
      bus.start  = 1'b1;
      cyc();
      bus.start  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(3);
      total_cnt++; if (bus.t_on !== 8'h00) $display("FAIL reset_t_on: got %h want 00", bus.t_on); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else pass_cnt++;
      total_cnt++; if (bus.note_idx !== 4'd0) $display("FAIL reset_idx: got %0d want 0", bus.note_idx); else pass_cnt++;
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_single_note();
      logic [N-1:0] exp_t [8];
      exp_t = '{8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F};
      wr_entry(4'd0, 16'h0032);
      wr_entry(4'd1, 16'h0000);
      go(8'h7F);
      total_cnt++; if (bus.busy !== 1'b1) $display("FAIL single_busy_e1: got %b want 1", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.t_on !== 8'h00) $display("FAIL single_t_on_e1: got %h want 00", bus.t_on); else pass_cnt++;
      for (int k = 0; k < 8; k++) begin
         cyc();
         total_cnt++;
         if (bus.t_on !== exp_t[k] || bus.busy !== 1'b1)
            $display("FAIL single_t_on_e%0d: got t_on=%h busy=%b want t_on=%h busy=1", k + 2, bus.t_on, bus.busy, exp_t[k]);
         else pass_cnt++;
      end
      cyc();
      total_cnt++;
      if (bus.t_on !== 8'h00 || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.note_idx !== 4'd1)
         $display("FAIL single_fetch_e10: got t_on=%h busy=%b done=%b idx=%0d want 00 1 0 1", bus.t_on, bus.busy, bus.done, bus.note_idx);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b1)
         $display("FAIL single_done_e11: got done=%b busy=%b want 1 1", bus.done, bus.busy);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL single_idle_e12: got done=%b busy=%b want 0 0", bus.done, bus.busy);
      else pass_cnt++;
   endtask

   task automatic test_rest_multi();
      logic [N-1:0] exp_t [4];
      exp_t = '{8'h7F, 8'h00, 8'h7F, 8'h00};
      wr_entry(4'd0, 16'h0001);
      wr_entry(4'd1, 16'h0011);
      wr_entry(4'd2, 16'h0000);
      go(8'h7F);
      for (int k = 0; k < 4; k++) begin
         cyc();
         total_cnt++;
         if (bus.t_on !== 8'h00 || bus.note_idx !== 4'd0)
            $display("FAIL rest_e%0d: got t_on=%h idx=%0d want 00 0", k + 2, bus.t_on, bus.note_idx);
         else pass_cnt++;
      end
      cyc();
      total_cnt++;
      if (bus.t_on !== 8'h00 || bus.note_idx !== 4'd1 || bus.busy !== 1'b1)
         $display("FAIL rest_fetch1: got t_on=%h idx=%0d busy=%b want 00 1 1", bus.t_on, bus.note_idx, bus.busy);
      else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         cyc();
         total_cnt++;
         if (bus.t_on !== exp_t[k] || bus.note_idx !== 4'd1)
            $display("FAIL hp1_e%0d: got t_on=%h idx=%0d want %h 1", k + 7, bus.t_on, bus.note_idx, exp_t[k]);
         else pass_cnt++;
      end
      cyc();
      total_cnt++;
      if (bus.note_idx !== 4'd2 || bus.done !== 1'b0)
         $display("FAIL multi_fetch2: got idx=%0d done=%b want 2 0", bus.note_idx, bus.done);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (bus.done !== 1'b1 || bus.note_idx !== 4'd2)
         $display("FAIL multi_done: got done=%b idx=%0d want 1 2", bus.done, bus.note_idx);
      else pass_cnt++;
      cyc();
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL multi_idle: got busy=%b want 0", bus.busy); else pass_cnt++;
   endtask

   task automatic test_full_table();
      int dones;
      int cycles;
      int busy_low;
      logic [AW-1:0] idx_at_done;
      logic [AW-1:0] prev_idx;
      logic wrapped;
      for (int a = 0; a < DEPTH; a++) wr_entry(AW'(a), 16'h0011);
      bus.loop = 1'b0;
      go(8'h7F);
      dones = 0; cycles = 0; idx_at_done = '0;
      while (bus.busy && cycles < 300) begin
         if (bus.done) begin
            dones++;
            idx_at_done = bus.note_idx;
         end
         cyc();
         cycles++;
      end
      // 16 notes of FETCH + 4 PLAY cycles, plus one END cycle
      total_cnt++; if (cycles !== 81) $display("FAIL full_len: got %0d cycles want 81", cycles); else pass_cnt++;
      total_cnt++; if (dones !== 1) $display("FAIL full_done_count: got %0d want 1", dones); else pass_cnt++;
      total_cnt++; if (idx_at_done !== 4'd15) $display("FAIL full_done_idx: got %0d want 15", idx_at_done); else pass_cnt++;

      bus.loop = 1'b1;
      go(8'h7F);
      dones = 0; busy_low = 0; wrapped = 1'b0; prev_idx = bus.note_idx;
      for (int c = 0; c < 100; c++) begin
         if (bus.done) dones++;
         if (!bus.busy) busy_low++;
         if (prev_idx == 4'd15 && bus.note_idx == 4'd0) wrapped = 1'b1;
         prev_idx = bus.note_idx;
         cyc();
      end
      total_cnt++; if (wrapped !== 1'b1) $display("FAIL loop_wrap: got %b want 1", wrapped); else pass_cnt++;
      total_cnt++; if (dones !== 0) $display("FAIL loop_no_done: got %0d want 0", dones); else pass_cnt++;
      total_cnt++; if (busy_low !== 0) $display("FAIL loop_busy: got %0d idle cycles want 0", busy_low); else pass_cnt++;
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      bus.loop = 1'b0;
      total_cnt++;
      if (bus.busy !== 1'b0 || bus.t_on !== 8'h00)
         $display("FAIL loop_stop: got busy=%b t_on=%h want 0 00", bus.busy, bus.t_on);
      else pass_cnt++;
   endtask

   task automatic test_stop_and_writes();
      wr_entry(4'd0, 16'h0032);
      wr_entry(4'd1, 16'h0000);
      go(8'h7F);
      cyc(2);
      bus.wr_addr = 4'd0;
      bus.wr_data = 16'h0000;
      bus.wr_en   = 1'b1;
      cyc();
      bus.wr_en   = 1'b0;
      total_cnt++; if (bus.t_on !== 8'h7F) $display("FAIL stop_pre: got %h want 7F", bus.t_on); else pass_cnt++;
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      total_cnt++;
      if (bus.t_on !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL stop_mid: got t_on=%h busy=%b done=%b want 00 0 0", bus.t_on, bus.busy, bus.done);
      else pass_cnt++;
      bus.stop = 1'b1;
      go(8'h7F);
      bus.stop = 1'b0;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL start_stop_idle: got busy=%b want 0", bus.busy); else pass_cnt++;
      bus.wr_addr = 4'd0;
      bus.wr_data = 16'h0000;
      bus.wr_en   = 1'b1;
      go(8'h7F);
      bus.wr_en   = 1'b0;
      cyc();
      total_cnt++; if (bus.t_on !== 8'h7F) $display("FAIL replay_e2: got %h want 7F", bus.t_on); else pass_cnt++;
      cyc(3);
      total_cnt++; if (bus.t_on !== 8'h00) $display("FAIL replay_e5: got %h want 00", bus.t_on); else pass_cnt++;
      cyc(7);
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL replay_end: got busy=%b want 0", bus.busy); else pass_cnt++;
   endtask

   task automatic test_volume();
      go(8'h7F);
      bus.volume = 8'h22;
      cyc();
      total_cnt++; if (bus.t_on !== 8'h7F) $display("FAIL vol_hold_e2: got %h want 7F", bus.t_on); else pass_cnt++;
      cyc(6);
      total_cnt++; if (bus.t_on !== 8'h7F) $display("FAIL vol_hold_e8: got %h want 7F", bus.t_on); else pass_cnt++;
      cyc(4);
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL vol_end: got busy=%b want 0", bus.busy); else pass_cnt++;
      go(8'h22);
      cyc();
      total_cnt++; if (bus.t_on !== 8'h22) $display("FAIL vol_new: got %h want 22", bus.t_on); else pass_cnt++;
      cyc(10);
   endtask

   task automatic test_reset_mid_play();
      bus.volume = 8'h7F;
      go(8'h7F);
      cyc(2);
      reset = 1'b1;
      cyc(3);
      total_cnt++;
      if (bus.t_on !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.note_idx !== 4'd0)
         $display("FAIL rstmid_in: got t_on=%h busy=%b done=%b idx=%0d want 00 0 0 0", bus.t_on, bus.busy, bus.done, bus.note_idx);
      else pass_cnt++;
      reset = 1'b0;
      cyc();
      total_cnt++;
      if (bus.t_on !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL rstmid_after: got t_on=%h busy=%b done=%b want 00 0 0", bus.t_on, bus.busy, bus.done);
      else pass_cnt++;
      go(8'h7F);
      cyc();
      total_cnt++; if (bus.t_on !== 8'h7F) $display("FAIL rstmid_replay_e2: got %h want 7F", bus.t_on); else pass_cnt++;
      cyc(3);
      total_cnt++; if (bus.t_on !== 8'h00) $display("FAIL rstmid_replay_e5: got %h want 00", bus.t_on); else pass_cnt++;
      cyc(5);
      total_cnt++; if (bus.note_idx !== 4'd1) $display("FAIL rstmid_replay_idx: got %0d want 1", bus.note_idx); else pass_cnt++;
      cyc();
      total_cnt++; if (bus.done !== 1'b1) $display("FAIL rstmid_replay_done: got %b want 1", bus.done); else pass_cnt++;
      cyc();
   endtask

   initial begin
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.loop    = 1'b0;
      bus.volume  = '0;
      #1;
      test_reset();
      test_single_note();
      test_rest_multi();
      test_full_table();
      test_stop_and_writes();
      test_volume();
      test_reset_mid_play();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Programmable note sequencer that drives the `t_on` duty input of the PWM DAC in the sound generator. It holds a small table of notes, each a square-wave half-period plus a duration. On command it plays the table in order, producing a square wave on `t_on` that alternates between a latched volume and 0. It sits between the top-level control inputs and the `dac` instance, replacing the constant duty value.

## Interface
Parameters:
- `N`, 8: DAC bitwidth; width of `volume` and `t_on`.
- `DEPTH`, 16: table entries; power of two.
- `AW`, 4: table address width, log2(`DEPTH`).
- `TICK_DIV`, 1000: clocks per duration tick, ≥2.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  table write strobe; honoured only in IDLE.
- `wr_addr`  in  AW  table write address.
- `wr_data`  in  16  table entry: [15:4] `hp` (half-period in clocks, 0 = rest), [3:0] `dur` (ticks, 0 = end marker).
- `start`  in  1  begin playback from entry 0; honoured only in IDLE.
- `stop`  in  1  abort playback; priority over `start`.
- `loop`  in  1  sampled in END; 1 = restart from entry 0.
- `volume`  in  N  high level of the tone; latched on accepted `start`.
- `t_on`  out  N  duty value to DAC.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `note_idx`  out  AW  index of the current entry.

## Operation
- States:
  - IDLE: the only state that accepts table writes and `start`.
  - FETCH: one cycle; latches `hp` and `dur` of entry `note_idx`.
  - PLAY: plays the latched note.
  - END: one cycle; ends the pass.
- IDLE:
  - `wr_en` writes `wr_data` to entry `wr_addr`.
  - `start`=1 and `stop`=0: latch `volume` into `vol_q`, set `note_idx`=0, go to FETCH.
- FETCH:
  - `dur`=0: go to END.
  - Otherwise go to PLAY with `phase`=1, tone counter 0, tick counter 0, remaining ticks = `dur`.
- PLAY, per clock:
  - Tone counter: when it equals `hp`-1, toggle `phase` and clear the counter; otherwise increment. The tone counter is inert when `hp`=0.
  - Tick counter: when it equals `TICK_DIV`-1, clear it and decrement the remaining-tick count.
  - When the count reaches 0 on a tick end:
    - `note_idx` = `DEPTH`-1: go to END, with `note_idx` unchanged.
    - Otherwise increment `note_idx` and go to FETCH.
- END:
  - `loop`=1: set `note_idx`=0, go to FETCH, no `done`.
  - `loop`=0: `done`=1 for this cycle, then go to IDLE.
- `stop`=1 in any non-IDLE state: go to IDLE next edge, with no `done`.
- `t_on` = `vol_q` when state is PLAY, `phase`=1 and `hp`≠0; otherwise 0.
  - Decoded from registers only; no input-to-output combinational path.
- Table storage:
  - Not cleared by `reset`; contents persist across reset and playback.
  - Writes outside IDLE are ignored, including in the same cycle `start` is accepted. The table is therefore stable during playback.
- `volume` changes during playback have no effect until the next `start`.

## Timing
- Reset values:
  - State IDLE.
  - `t_on`=0, `busy`=0, `done`=0, `note_idx`=0.
  - `vol_q`=0, `phase`=0, all counters 0.
- Reset mid-playback: IDLE with reset values on the next edge; no `done`.
- Start latency: `start` sampled at edge E gives FETCH after E. The first PLAY cycle (after E+1) already shows `t_on`=`vol_q`.
- Note length:
  - PLAY lasts exactly `dur`×`TICK_DIV` cycles.
  - Each note costs 1 extra FETCH cycle.
  - END costs 1 cycle.
- Tone shape: `hp` cycles high, `hp` cycles low, repeating, starting high. A partial last half-period is truncated at the note end.
- `hp`=1: `t_on` alternates every cycle.
- `done` is asserted during the END cycle. `busy` falls in the following cycle.
- `stop` and `start` together in IDLE: stays IDLE.
- `stop` in FETCH or END: IDLE next edge; it wins over all transitions.

## Test plan
- Reset: hold `reset` 3 cycles mid-play, then release.
  - Required: `t_on`=0, `busy`=0, `done`=0, `note_idx`=0.
  - Required: table preserved; a re-`start` replays the same notes.
- Single note (`TICK_DIV`=4, entry0 = `hp` 3 / `dur` 2, entry1 = `dur` 0, `volume`=0x7F, `start` at edge 0):
  - Edges 2..9 show `t_on` = 7F,7F,7F,0,0,0,7F,7F.
  - Edge 10 is FETCH; `done`=1 at edge 11.
  - `busy`=1 on edges 1..11 and 0 at edge 12.
- Rest and multi-note (entry0 = `hp` 0 / `dur` 1, entry1 = `hp` 1 / `dur` 1, entry2 terminator, `TICK_DIV`=4):
  - Required: `t_on`=0 for 4 cycles, 1 FETCH cycle, then 7F,0,7F,0.
  - Required: `note_idx` steps 0→1→2.
- Full table with no terminator, `loop`=0: END is reached after index 15 and `done` pulses once.
  - Same table with `loop`=1: `note_idx` wraps 15→0 via END→FETCH, no `done`, continuous playback.
- `stop` mid-note: `t_on`=0 and `busy`=0 on the next edge, no `done`.
  - `wr_en` asserted during playback leaves the table unchanged; verify on replay.
- `volume` changed during PLAY: `t_on` keeps the old value until the next `start`.
